// File: rtl/alarm_clock_pkg.sv
// Shared encodings and widths for the alarm clock time/alarm datapath.
package alarm_clock_pkg;

  localparam logic [2:0] MODE_A = 3'd0;
  localparam logic [2:0] MODE_B = 3'd1;
  localparam logic [2:0] MODE_C = 3'd2;
  localparam logic [2:0] MODE_D = 3'd3;
  localparam logic [2:0] MODE_E = 3'd4;

  localparam int HOUR_MOD = 24;
  localparam int MIN_MOD  = 60;
  localparam int SEC_MOD  = 60;

  localparam int HOUR_W = 5;
  localparam int MIN_W  = 6;

  typedef enum logic [1:0] {IDLE, RINGING, DONE} ring_state_t;

endpackage

// File: rtl/mod_counter.sv
// Modulo up/down counter with synchronous clear; wrap_up flags an up-step out of MODULUS-1.
module mod_counter #(
  parameter int MODULUS = 60,
  parameter int WIDTH   = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             up,
  input  logic             down,
  output logic [WIDTH-1:0] value,
  output logic             wrap_up
);

  localparam logic [WIDTH-1:0] LAST = WIDTH'(MODULUS - 1);

  logic step_up;
  logic step_down;

  assign step_up   = up && !down;
  assign step_down = down && !up;
  assign wrap_up   = step_up && (value == LAST);

  always_ff @(posedge clk) begin
    if (!rst) begin
      value <= '0;
    end else if (clr) begin
      value <= '0;
    end else if (step_up) begin
      value <= (value == LAST) ? '0 : value + 1'b1;
    end else if (step_down) begin
      value <= (value == '0) ? LAST : value - 1'b1;
    end
  end

endmodule

// File: rtl/clock_time_keeper.sv
// Running time, alarm setting and ring control; display values are muxed by the current mode.
module clock_time_keeper
  import alarm_clock_pkg::*;
#(
  parameter int RING_SECS = 60
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sec_tick,
  input  logic [2:0]        mode,
  input  logic              inc_pulse,
  input  logic              dec_pulse,
  input  logic              stop_pulse,
  input  logic              alarm_en,
  output logic [HOUR_W-1:0] time_hour,
  output logic [MIN_W-1:0]  time_min,
  output logic [MIN_W-1:0]  time_sec,
  output logic [HOUR_W-1:0] alarm_hour,
  output logic [MIN_W-1:0]  alarm_min,
  output logic [HOUR_W-1:0] disp_hour,
  output logic [MIN_W-1:0]  disp_min,
  output logic              dp,
  output logic              alarm_ring
);

  localparam logic [7:0] RING_LAST = 8'(RING_SECS - 1);

  logic mode_a, mode_b, mode_c, mode_d, mode_e;
  logic edit;
  logic sec_wrap, min_wrap, hour_wrap, amin_wrap, ahour_wrap;
  logic unused_wraps;
  logic match;

  ring_state_t state, state_nxt;
  logic [7:0]  ring_cnt, ring_cnt_nxt;

  // Undefined encodings 101..111 fall back to run mode.
  assign mode_b = (mode == MODE_B);
  assign mode_c = (mode == MODE_C);
  assign mode_d = (mode == MODE_D);
  assign mode_e = (mode == MODE_E);
  assign mode_a = !(mode_b || mode_c || mode_d || mode_e);

  // Only a lone inc or dec is an edit; both together leave seconds alone too.
  assign edit = inc_pulse ^ dec_pulse;

  mod_counter #(.MODULUS(SEC_MOD), .WIDTH(MIN_W)) u_sec (
    .clk(clk), .rst(rst),
    .clr((mode_b || mode_c) && edit),
    .up(mode_a && sec_tick),
    .down(1'b0),
    .value(time_sec), .wrap_up(sec_wrap)
  );

  mod_counter #(.MODULUS(MIN_MOD), .WIDTH(MIN_W)) u_min (
    .clk(clk), .rst(rst), .clr(1'b0),
    .up(mode_a ? sec_wrap : (mode_c && inc_pulse)),
    .down(mode_c && dec_pulse),
    .value(time_min), .wrap_up(min_wrap)
  );

  mod_counter #(.MODULUS(HOUR_MOD), .WIDTH(HOUR_W)) u_hour (
    .clk(clk), .rst(rst), .clr(1'b0),
    .up(mode_a ? min_wrap : (mode_b && inc_pulse)),
    .down(mode_b && dec_pulse),
    .value(time_hour), .wrap_up(hour_wrap)
  );

  mod_counter #(.MODULUS(MIN_MOD), .WIDTH(MIN_W)) u_alarm_min (
    .clk(clk), .rst(rst), .clr(1'b0),
    .up(mode_e && inc_pulse),
    .down(mode_e && dec_pulse),
    .value(alarm_min), .wrap_up(amin_wrap)
  );

  mod_counter #(.MODULUS(HOUR_MOD), .WIDTH(HOUR_W)) u_alarm_hour (
    .clk(clk), .rst(rst), .clr(1'b0),
    .up(mode_d && inc_pulse),
    .down(mode_d && dec_pulse),
    .value(alarm_hour), .wrap_up(ahour_wrap)
  );

  assign unused_wraps = &{1'b0, hour_wrap, amin_wrap, ahour_wrap};

  always_ff @(posedge clk) begin
    if (!rst) begin
      dp <= 1'b0;
    end else if (!mode_a) begin
      dp <= 1'b1;
    end else if (sec_tick) begin
      dp <= ~dp;
    end
  end

  assign match = alarm_en && mode_a && (time_hour == alarm_hour) &&
                 (time_min == alarm_min) && (time_sec == '0);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= DONE;
      ring_cnt <= '0;
    end else begin
      state    <= state_nxt;
      ring_cnt <= ring_cnt_nxt;
    end
  end

  // DONE waits for the match to clear so one matching second rings only once.
  always_comb begin
    state_nxt    = state;
    ring_cnt_nxt = ring_cnt;
    case (state)
      IDLE: begin
        if (match) begin
          state_nxt    = RINGING;
          ring_cnt_nxt = '0;
        end
      end
      RINGING: begin
        if (stop_pulse || !alarm_en || !mode_a) begin
          state_nxt = DONE;
        end else if (sec_tick) begin
          ring_cnt_nxt = ring_cnt + 8'd1;
          if (ring_cnt == RING_LAST) state_nxt = DONE;
        end
      end
      DONE: begin
        if (!match) state_nxt = IDLE;
      end
      default: state_nxt = DONE;
    endcase
  end

  assign alarm_ring = (state == RINGING);

  assign disp_hour = (mode_d || mode_e) ? alarm_hour : time_hour;
  assign disp_min  = (mode_d || mode_e) ? alarm_min  : time_min;

endmodule

// File: tb/tb_clock_time_keeper.sv
// Directed scoreboard bench for clock_time_keeper: stimulus queues expectations, a monitor checks them.
module tb_clock_time_keeper;
  import alarm_clock_pkg::*;

  logic       clk;
  logic       rst;
  logic       sec_tick;
  logic [2:0] mode;
  logic       inc_pulse;
  logic       dec_pulse;
  logic       stop_pulse;
  logic       alarm_en;
  logic [4:0] time_hour;
  logic [5:0] time_min;
  logic [5:0] time_sec;
  logic [4:0] alarm_hour;
  logic [5:0] alarm_min;
  logic [4:0] disp_hour;
  logic [5:0] disp_min;
  logic       dp;
  logic       alarm_ring;

  clock_time_keeper #(.RING_SECS(60)) dut (
    .clk(clk), .rst(rst), .sec_tick(sec_tick), .mode(mode),
    .inc_pulse(inc_pulse), .dec_pulse(dec_pulse), .stop_pulse(stop_pulse),
    .alarm_en(alarm_en),
    .time_hour(time_hour), .time_min(time_min), .time_sec(time_sec),
    .alarm_hour(alarm_hour), .alarm_min(alarm_min),
    .disp_hour(disp_hour), .disp_min(disp_min),
    .dp(dp), .alarm_ring(alarm_ring)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string name;
    int th, tm, ts, ah, am, dh, dm, dpv, ring;
  } exp_t;

  exp_t exp_q[$];
  exp_t cur;
  int   n_tests = 0;
  int   n_failed = 0;

  task automatic chk(input string nm, input string fld, input int act, input int req);
    if (req >= 0) begin
      n_tests++;
      if (act != req) begin
        n_failed++;
        $display("FAIL %s.%s: got %0d expected %0d", nm, fld, act, req);
      end
    end
  endtask

  // Monitor: every expectation queued before an edge is checked just after it.
  always @(posedge clk) begin
    #1;
    while (exp_q.size() > 0) begin
      cur = exp_q.pop_front();
      chk(cur.name, "time_hour", int'(time_hour), cur.th);
      chk(cur.name, "time_min", int'(time_min), cur.tm);
      chk(cur.name, "time_sec", int'(time_sec), cur.ts);
      chk(cur.name, "alarm_hour", int'(alarm_hour), cur.ah);
      chk(cur.name, "alarm_min", int'(alarm_min), cur.am);
      chk(cur.name, "disp_hour", int'(disp_hour), cur.dh);
      chk(cur.name, "disp_min", int'(disp_min), cur.dm);
      chk(cur.name, "dp", int'(dp), cur.dpv);
      chk(cur.name, "alarm_ring", int'(alarm_ring), cur.ring);
    end
  end

  task automatic step(input logic rs, input logic en, input logic [2:0] m,
                      input logic tk, input logic in, input logic dc, input logic sp);
    @(negedge clk);
    rst        = rs;
    alarm_en   = en;
    mode       = m;
    sec_tick   = tk;
    inc_pulse  = in;
    dec_pulse  = dc;
    stop_pulse = sp;
  endtask

  task automatic ex(input string nm, input int th, input int tm, input int ts,
                    input int ah, input int am, input int dh, input int dm,
                    input int dpv, input int ring);
    exp_t e;
    e.name = nm; e.th = th; e.tm = tm; e.ts = ts; e.ah = ah; e.am = am;
    e.dh = dh; e.dm = dm; e.dpv = dpv; e.ring = ring;
    exp_q.push_back(e);
  endtask

  // From 07:29:00 with alarm 07:30 armed: run to 07:30:00, then ringing one cycle later.
  task automatic ring_up(input string nm);
    for (int k = 1; k <= 59; k++) step(1, 1, MODE_A, 1, 0, 0, 0);
    step(1, 1, MODE_A, 1, 0, 0, 0);
    ex({nm, "_match"}, 7, 30, 0, 7, 30, 7, 30, -1, 0);
    step(1, 1, MODE_A, 0, 0, 0, 0);
    ex({nm, "_ring"}, 7, 30, 0, 7, 30, 7, 30, -1, 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; alarm_en = 1'b0; mode = MODE_A; sec_tick = 1'b0;
    inc_pulse = 1'b0; dec_pulse = 1'b0; stop_pulse = 1'b0;

    step(0, 0, MODE_A, 0, 0, 0, 0);
    ex("reset", 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, MODE_A, 1, 1, 0, 1);
    ex("reset_dominates", 0, 0, 0, 0, 0, 0, 0, 0, 0);

    step(1, 0, MODE_A, 1, 0, 0, 0);
    ex("tick1", 0, 0, 1, 0, 0, 0, 0, 1, 0);
    step(1, 0, MODE_A, 1, 1, 0, 0);
    ex("tick2_inc_ignored", 0, 0, 2, 0, 0, 0, 0, 0, 0);
    step(1, 0, MODE_A, 0, 0, 1, 0);
    ex("idle_dec_ignored", 0, 0, 2, 0, 0, 0, 0, 0, 0);

    step(1, 0, MODE_B, 0, 0, 1, 0);
    ex("b_dec_wrap", 23, 0, 0, 0, 0, 23, 0, 1, 0);
    step(1, 0, MODE_B, 0, 1, 0, 0);
    ex("b_inc_wrap", 0, 0, 0, 0, 0, 0, 0, 1, 0);
    step(1, 0, MODE_B, 1, 0, 0, 0);
    ex("b_tick_frozen", 0, 0, 0, 0, 0, 0, 0, 1, 0);
    step(1, 0, MODE_A, 1, 0, 0, 0);
    step(1, 0, MODE_A, 1, 0, 0, 0);
    ex("a_resume", 0, 0, 2, 0, 0, 0, 0, 1, 0);
    step(1, 0, MODE_B, 0, 1, 1, 0);
    ex("b_incdec_nop", 0, 0, 2, 0, 0, 0, 0, 1, 0);
    step(1, 0, MODE_C, 0, 0, 1, 0);
    ex("c_dec_wrap", 0, 59, 0, 0, 0, 0, 59, 1, 0);
    step(1, 0, MODE_C, 0, 1, 0, 0);
    ex("c_inc_nocarry", 0, 0, 0, 0, 0, 0, 0, 1, 0);

    for (int k = 0; k < 7; k++) step(1, 0, MODE_D, 0, 1, 0, 0);
    ex("d_set_hour", 0, 0, 0, 7, 0, 7, 0, 1, 0);
    step(1, 0, MODE_E, 0, 0, 1, 0);
    ex("e_dec_wrap", 0, 0, 0, 7, 59, 7, 59, 1, 0);
    for (int k = 0; k < 31; k++) step(1, 0, MODE_E, 0, 1, 0, 0);
    ex("e_set_min", 0, 0, 0, 7, 30, 7, 30, 1, 0);
    for (int k = 0; k < 7; k++) step(1, 0, MODE_B, 0, 1, 0, 0);
    for (int k = 0; k < 31; k++) step(1, 0, MODE_C, 0, 0, 1, 0);
    ex("c_set_time", 7, 29, 0, 7, 30, 7, 29, 1, 0);
    step(1, 1, MODE_A, 0, 0, 0, 0);
    ex("a_disp_time", 7, 29, 0, 7, 30, 7, 29, 1, 0);

    ring_up("r1");
    for (int k = 1; k <= 60; k++) begin
      step(1, 1, MODE_A, 1, 0, 0, 0);
      if (k == 59) ex("ring_hold", 7, 30, 59, 7, 30, 7, 30, 0, 1);
      if (k == 60) ex("ring_timeout", 7, 31, 0, 7, 30, 7, 31, 1, 0);
    end

    step(1, 1, MODE_C, 0, 0, 1, 0);
    step(1, 1, MODE_C, 0, 0, 1, 0);
    ex("c_back", 7, 29, 0, 7, 30, 7, 29, 1, 0);
    ring_up("r2");
    step(1, 1, MODE_A, 0, 0, 0, 1);
    ex("stop", 7, 30, 0, 7, 30, 7, 30, -1, 0);
    step(1, 1, MODE_A, 0, 0, 0, 0);
    ex("no_retrigger", 7, 30, 0, 7, 30, 7, 30, -1, 0);
    step(1, 1, MODE_A, 1, 0, 0, 0);
    ex("next_sec", 7, 30, 1, 7, 30, 7, 30, -1, 0);

    step(1, 1, MODE_C, 0, 0, 1, 0);
    ex("c_back2", 7, 29, 0, 7, 30, 7, 29, 1, 0);
    ring_up("r3");
    step(1, 1, MODE_A, 1, 0, 0, 1);
    ex("stop_with_tick", 7, 30, 1, 7, 30, 7, 30, -1, 0);

    step(1, 1, MODE_C, 0, 0, 1, 0);
    ring_up("r4");
    step(1, 1, MODE_D, 0, 0, 0, 0);
    ex("mode_d_stops", 7, 30, 0, 7, 30, 7, 30, 1, 0);

    step(1, 1, MODE_C, 0, 0, 1, 0);
    ring_up("r5");
    step(1, 0, MODE_A, 0, 0, 0, 0);
    ex("en_off", 7, 30, 0, 7, 30, 7, 30, -1, 0);

    step(1, 1, MODE_C, 0, 0, 1, 0);
    ring_up("r6");
    step(0, 1, MODE_A, 1, 0, 0, 0);
    ex("reset_mid_ring", 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 1, MODE_A, 0, 0, 0, 0);
    ex("post_reset_no_ring", 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 1, MODE_A, 0, 0, 0, 0);
    ex("post_reset_still", 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 1, MODE_A, 1, 0, 0, 0);
    ex("post_reset_tick", 0, 0, 1, 0, 0, 0, 0, 1, 0);

    step(1, 1, MODE_B, 0, 0, 1, 0);
    step(1, 1, MODE_C, 0, 0, 1, 0);
    ex("pre_midnight", 23, 59, 0, 0, 0, 23, 59, 1, 0);
    for (int k = 1; k <= 60; k++) begin
      step(1, 1, MODE_A, 1, 0, 0, 0);
      if (k == 59) ex("last_second", 23, 59, 59, 0, 0, 23, 59, 0, 0);
      if (k == 60) ex("midnight", 0, 0, 0, 0, 0, 0, 0, 1, 0);
    end
    step(1, 1, MODE_A, 0, 0, 0, 0);
    ex("midnight_ring", 0, 0, 0, 0, 0, 0, 0, 1, 1);
    step(1, 1, MODE_A, 0, 0, 0, 1);
    ex("midnight_stop", 0, 0, 0, 0, 0, 0, 0, 1, 0);
    step(1, 1, 3'b101, 1, 0, 0, 0);
    ex("mode5_runs", 0, 0, 1, 0, 0, 0, 0, 0, 0);

    step(1, 1, MODE_A, 0, 0, 0, 0);
    @(posedge clk);
    #2;
    n_tests++;
    if (exp_q.size() != 0) begin
      n_failed++;
      $display("FAIL queue_drain: got %0d pending expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_failed);
    $finish;
  end

endmodule
